// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Raster timing bundle between the timing generator (master)
//               and the drawing/overlay stages that consume it (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_gen_if;
    logic        en;            // pixel-advance enable, driven by the consumer side
    logic [10:0] hcount;        // horizontal position
    logic [10:0] vcount;        // vertical position
    logic        hsync;         // horizontal sync at configured polarity
    logic        vsync;         // vertical sync at configured polarity
    logic        hblnk;         // horizontal blanking
    logic        vblnk;         // vertical blanking
    logic        frame_start;   // one-cycle strobe at pixel (0,0)

    // Timing generator side
    modport master (
        input  en,
        output hcount,
        output vcount,
        output hsync,
        output vsync,
        output hblnk,
        output vblnk,
        output frame_start
    );

    // Video pipeline side
    modport slave (
        output en,
        input  hcount,
        input  vcount,
        input  hsync,
        input  vsync,
        input  hblnk,
        input  vblnk,
        input  frame_start
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : Raster timing generator. Two wrapping counters with
//               comparator decode; every output is registered from the
//               next-state counter values so all outputs describe the same
//               pixel as the hcount/vcount presented alongside them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  wire logic         pclk,
    input  wire logic         rst,      // active-low, synchronous
    vga_timing_gen_if.master  bus
);

    // Geometry constants, all reduced to the 11-bit compare domain
    localparam logic [10:0] c_h_last     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] c_v_last     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] c_h_active   = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_active   = 11'(V_ACTIVE);
    localparam logic [10:0] c_hs_start   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] c_vs_start   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_end     = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q,  hsync_d;
    logic        vsync_q,  vsync_d;
    logic        hblnk_q,  hblnk_d;
    logic        vblnk_q,  vblnk_d;
    logic        fstart_q, fstart_d;

    // Advance values for the counters; only taken when en is high
    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == c_h_last) begin
            hcount_d = 11'd0;
            if (vcount_q == c_v_last) begin
                vcount_d = 11'd0;
            end else begin
                vcount_d = vcount_q + 11'd1;
            end
        end
    end

    // Decode on the advance values so the registered flags line up with the counters
    always_comb begin
        hblnk_d  = (hcount_d >= c_h_active);
        vblnk_d  = (vcount_d >= c_v_active);
        hsync_d  = ((hcount_d >= c_hs_start) && (hcount_d <= c_hs_end)) ? HS_POL : ~HS_POL;
        // vcount only moves on the line wrap, so vsync changes with hcount==0
        vsync_d  = ((vcount_d >= c_vs_start) && (vcount_d <= c_vs_end)) ? VS_POL : ~VS_POL;
        fstart_d = (hcount_d == 11'd0) && (vcount_d == 11'd0);
    end

    // State registers: reset beats enable; the strobe self-clears while stalled
    always_ff @(posedge pclk) begin
        if (!rst) begin
            hcount_q <= 11'd0;
            vcount_q <= 11'd0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            fstart_q <= 1'b0;
        end else if (bus.en) begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            fstart_q <= fstart_d;
        end else begin
            fstart_q <= 1'b0;
        end
    end

    assign bus.hcount      = hcount_q;
    assign bus.vcount      = vcount_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.hblnk       = hblnk_q;
    assign bus.vblnk       = vblnk_q;
    assign bus.frame_start = fstart_q;

endmodule

`default_nettype wire
